// File: rtl/hazard_detect_pkg.sv
// hazard_detect_pkg
//   Shared definitions for the hazard detection slice: register index width,
//   the hazard FSM state encodings and the LOAD opcode used upstream to
//   derive ex_is_load.
package hazard_detect_pkg;

    // Register file index width (32 architectural registers).
    localparam int REG_ADDR_W = 5;

    // Hazard FSM state encodings (kept as plain constants for compatibility
    // with the existing decode of the debug bus).
    typedef logic [1:0] hz_state_t;
    localparam hz_state_t ST_IDLE   = 2'd0;
    localparam hz_state_t ST_STALL  = 2'd1;
    localparam hz_state_t ST_SHADOW = 2'd2;

    // RV32I LOAD major opcode; the execute stage compares against this to
    // produce ex_is_load.
    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear, used for debug event
//   counters.
// Ports:
//   clk  in   clock
//   clr  in   synchronous clear (highest priority)
//   inc  in   count enable; ignored once q is all-ones
//   q    out  current count
module sat_counter
    import hazard_detect_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detect.sv
// hazard_detect
//   Producer side of the pipeline halt interface. Detects taken branches and
//   load-use hazards from the decode/execute fields, issues a one-cycle
//   branch_en pulse or a load_stall request (registered, one cycle after the
//   qualifying inputs), and suppresses new requests during the branch shadow.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   dec_*              decode-stage valid, source registers and usage flags
//   ex_*               execute-stage valid, load flag, destination, taken branch
//   halt_exec          execute stage halted this cycle
//   branch_en          branch flush pulse to the halt controller
//   load_stall         hold fetch/decode and bubble execute
//   busy               FSM not in IDLE
//   branch_cnt         saturating count of branch_en pulses
//   stall_cnt          saturating count of load_stall cycles
module hazard_detect #(
    parameter int REG_ADDR_W        = hazard_detect_pkg::REG_ADDR_W,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_SHADOW     = 4,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_use_rs1,
    input  logic                  dec_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  halt_exec,
    output logic                  branch_en,
    output logic                  load_stall,
    output logic                  busy,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    import hazard_detect_pkg::*;

    // The down-counter only ever holds (length - 1), so it needs enough bits
    // for max(BRANCH_SHADOW, LOAD_STALL_CYCLES) - 1.
    localparam int CNT_MAX = max2(BRANCH_SHADOW, LOAD_STALL_CYCLES);
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] SHADOW_LOAD = CW'(BRANCH_SHADOW - 1);
    localparam logic [CW-1:0] STALL_LOAD  = CW'(LOAD_STALL_CYCLES - 1);

    hz_state_t      state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           branch_nx, stall_nx;
    logic           br_hit, lu_hit;
    logic           rs1_match, rs2_match;

    // x0 is hard-wired to zero, so a load targeting it creates no dependency.
    assign rs1_match = dec_use_rs1 && (dec_rs1 == ex_rd);
    assign rs2_match = dec_use_rs2 && (dec_rs2 == ex_rd);

    assign br_hit = ex_valid && ex_branch_taken && !halt_exec;
    assign lu_hit = dec_valid && ex_valid && ex_is_load && !halt_exec &&
                    (ex_rd != '0) && (rs1_match || rs2_match);

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        branch_nx = 1'b0;
        stall_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Branch wins over load-use: the flush kills the dependent
                // instruction, so stalling it would be wasted.
                if (br_hit) begin
                    branch_nx = 1'b1;
                    state_nx  = ST_SHADOW;
                    cnt_nx    = SHADOW_LOAD;
                end else if (lu_hit) begin
                    stall_nx = 1'b1;
                    if (STALL_LOAD != '0) begin
                        state_nx = ST_STALL;
                        cnt_nx   = STALL_LOAD;
                    end
                end
            end
            ST_STALL: begin
                if (br_hit) begin
                    branch_nx = 1'b1;
                    state_nx  = ST_SHADOW;
                    cnt_nx    = SHADOW_LOAD;
                end else if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    stall_nx = 1'b1;
                    cnt_nx   = cnt - 1'b1;
                end
            end
            ST_SHADOW: begin
                // Instructions seen here are being flushed; ignore them.
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            branch_en  <= 1'b0;
            load_stall <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            branch_en  <= branch_nx;
            load_stall <= stall_nx;
        end
    end

    assign busy = (state != ST_IDLE);

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (branch_en),
        .q   (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (load_stall),
        .q   (stall_cnt)
    );

endmodule
